// File: rtl/distinct_history_tracker.sv
// Keeps the last DEPTH distinct qualified samples newest-first, with hit/evict reporting.
// Latency 2 edges (input stage, then slot update); accepts one sample per cycle and never stalls.
module distinct_history_tracker #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic                     mode_in,
  input  logic                     flush_in,
  output logic [DEPTH*DATA_W-1:0]  out_data,
  output logic [DEPTH-1:0]         out_valid,
  output logic [CW-1:0]            count_out,
  output logic                     hit_out,
  output logic [IW-1:0]            hit_idx_out,
  output logic                     evict_valid_out,
  output logic [DATA_W-1:0]        evict_data_out
);

  logic [DATA_W-1:0]             r_s_data;
  logic                          r_s_vld;
  logic                          r_s_mode;
  logic                          r_s_flush;

  logic [DEPTH-1:0][DATA_W-1:0]  r_slots;
  logic [DEPTH-1:0]              r_vld;
  logic [CW-1:0]                 r_count;
  logic                          r_hit;
  logic [IW-1:0]                 r_hit_idx;
  logic                          r_ev;
  logic [DATA_W-1:0]             r_ev_data;

  logic                          w_hit;
  logic [IW-1:0]                 w_hit_idx;
  logic [DEPTH-1:0][DATA_W-1:0]  w_slots_nx;
  logic [DEPTH-1:0]              w_vld_nx;
  logic [CW-1:0]                 w_cnt_nx;
  logic                          w_hit_nx;
  logic [IW-1:0]                 w_idx_nx;
  logic                          w_ev_nx;
  logic [DATA_W-1:0]             w_ed_nx;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_s_data  <= '0;
      r_s_vld   <= 1'b0;
      r_s_mode  <= 1'b0;
      r_s_flush <= 1'b0;
    end else begin
      r_s_data  <= data_in;
      r_s_vld   <= valid_in;
      r_s_mode  <= mode_in;
      r_s_flush <= flush_in;
    end
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_slots[i] == r_s_data)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_slots_nx = r_slots;
    w_vld_nx   = r_vld;
    w_cnt_nx   = r_count;
    w_hit_nx   = 1'b0;
    w_idx_nx   = '0;
    w_ev_nx    = 1'b0;
    w_ed_nx    = '0;
    if (r_s_flush) begin
      w_slots_nx = '0;
      w_vld_nx   = '0;
      w_cnt_nx   = '0;
      if (r_s_vld) begin
        w_slots_nx[0] = r_s_data;
        w_vld_nx[0]   = 1'b1;
        w_cnt_nx      = CW'(1);
      end
    end else if (r_s_vld) begin
      if (!w_hit) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          w_slots_nx[i] = r_slots[i-1];
        end
        w_slots_nx[0] = r_s_data;
        w_vld_nx      = {r_vld[DEPTH-2:0], 1'b1};
        if (r_vld[DEPTH-1]) begin
          w_ev_nx = 1'b1;
          w_ed_nx = r_slots[DEPTH-1];
        end else begin
          w_cnt_nx = r_count + CW'(1);
        end
      end else begin
        w_hit_nx = 1'b1;
        w_idx_nx = w_hit_idx;
        if (!r_s_mode) begin
          for (int i = 1; i < DEPTH; i++) begin
            if (i <= int'(w_hit_idx)) begin
              w_slots_nx[i] = r_slots[i-1];
            end
          end
          w_slots_nx[0] = r_s_data;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_slots   <= '0;
      r_vld     <= '0;
      r_count   <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_ev      <= 1'b0;
      r_ev_data <= '0;
    end else begin
      r_slots   <= w_slots_nx;
      r_vld     <= w_vld_nx;
      r_count   <= w_cnt_nx;
      r_hit     <= w_hit_nx;
      r_hit_idx <= w_idx_nx;
      r_ev      <= w_ev_nx;
      r_ev_data <= w_ed_nx;
    end
  end

  assign out_data        = r_slots;
  assign out_valid       = r_vld;
  assign count_out       = r_count;
  assign hit_out         = r_hit;
  assign hit_idx_out     = r_hit_idx;
  assign evict_valid_out = r_ev;
  assign evict_data_out  = r_ev_data;

endmodule

// File: tb/tb_distinct_history_tracker.sv
// Directed bench for distinct_history_tracker (DATA_W=8, DEPTH=4): stimulus queues
// hand-computed expected output snapshots, a monitor compares them on their due cycle.
module tb_distinct_history_tracker;

  logic        clk;
  logic        reset_in;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        mode_in;
  logic        flush_in;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [2:0]  count_out;
  logic        hit_out;
  logic [1:0]  hit_idx_out;
  logic        evict_valid_out;
  logic [7:0]  evict_data_out;

  distinct_history_tracker #(.DATA_W(8), .DEPTH(4)) dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .mode_in         (mode_in),
    .flush_in        (flush_in),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .count_out       (count_out),
    .hit_out         (hit_out),
    .hit_idx_out     (hit_idx_out),
    .evict_valid_out (evict_valid_out),
    .evict_data_out  (evict_data_out)
  );

  typedef struct {
    int          due;
    logic [31:0] od;
    logic [3:0]  ov;
    logic [2:0]  cnt;
    logic        h;
    logic [1:0]  hi;
    logic        ev;
    logic [7:0]  ed;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int due, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, due, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) begin
        checks++;
        failures++;
        $display("FAIL late_entry due=%0d now=%0d", e.due, cyc);
      end else begin
        chk("out_data",        e.due, out_data,                e.od);
        chk("out_valid",       e.due, {28'd0, out_valid},      {28'd0, e.ov});
        chk("count_out",       e.due, {29'd0, count_out},      {29'd0, e.cnt});
        chk("hit_out",         e.due, {31'd0, hit_out},        {31'd0, e.h});
        chk("hit_idx_out",     e.due, {30'd0, hit_idx_out},    {30'd0, e.hi});
        chk("evict_valid_out", e.due, {31'd0, evict_valid_out}, {31'd0, e.ev});
        chk("evict_data_out",  e.due, {24'd0, evict_data_out}, {24'd0, e.ed});
      end
    end
  end

  // Presents one sample; the expected snapshot is due two edges later.
  task automatic step(input logic [7:0] d, input logic v, input logic m, input logic f,
                      input logic [31:0] od, input logic [3:0] ov, input logic [2:0] c,
                      input logic h, input logic [1:0] hi, input logic ev, input logic [7:0] ed,
                      input bit expect_it = 1'b1);
    exp_t e;
    @(negedge clk);
    reset_in = 1'b0;
    data_in  = d;
    valid_in = v;
    mode_in  = m;
    flush_in = f;
    if (expect_it) begin
      e.due = cyc + 2; e.od = od; e.ov = ov; e.cnt = c;
      e.h = h; e.hi = hi; e.ev = ev; e.ed = ed;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    z.od = '0; z.ov = '0; z.cnt = '0; z.h = 1'b0; z.hi = '0; z.ev = 1'b0; z.ed = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_in = 1'b1;
      data_in  = 8'd0;
      valid_in = 1'b0;
      mode_in  = 1'b0;
      flush_in = 1'b0;
      z.due = cyc + 1;
      q.push_back(z);
    end
    // Stage is empty after reset, so the next edge also leaves everything at 0.
    z.due = cyc + 2;
    q.push_back(z);
  endtask

  initial begin
    reset_in = 1'b1;
    data_in  = 8'd0;
    valid_in = 1'b0;
    mode_in  = 1'b0;
    flush_in = 1'b0;
    do_reset(2);

    // Move-to-front stream 1 2 3 4 3 2 3 4 3 4
    step(8'd1, 1, 0, 0, 32'h00000001, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);
    step(8'd2, 1, 0, 0, 32'h00000102, 4'b0011, 3'd2, 0, 2'd0, 0, 8'd0);
    step(8'd3, 1, 0, 0, 32'h00010203, 4'b0111, 3'd3, 0, 2'd0, 0, 8'd0);
    step(8'd4, 1, 0, 0, 32'h01020304, 4'b1111, 3'd4, 0, 2'd0, 0, 8'd0);
    step(8'd3, 1, 0, 0, 32'h01020403, 4'b1111, 3'd4, 1, 2'd1, 0, 8'd0);
    step(8'd2, 1, 0, 0, 32'h01040302, 4'b1111, 3'd4, 1, 2'd2, 0, 8'd0);
    step(8'd3, 1, 0, 0, 32'h01040203, 4'b1111, 3'd4, 1, 2'd1, 0, 8'd0);
    step(8'd4, 1, 0, 0, 32'h01020304, 4'b1111, 3'd4, 1, 2'd2, 0, 8'd0);
    step(8'd3, 1, 0, 0, 32'h01020403, 4'b1111, 3'd4, 1, 2'd1, 0, 8'd0);
    step(8'd4, 1, 0, 0, 32'h01020304, 4'b1111, 3'd4, 1, 2'd1, 0, 8'd0);

    // Flush with a valid sample, then a bare flush
    step(8'd6, 1, 0, 1, 32'h00000006, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);
    step(8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 3'd0, 0, 2'd0, 0, 8'd0);

    // Keep-order stream 1 2 1 2 1, then one move-to-front hit
    step(8'd1, 1, 1, 0, 32'h00000001, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);
    step(8'd2, 1, 1, 0, 32'h00000102, 4'b0011, 3'd2, 0, 2'd0, 0, 8'd0);
    step(8'd1, 1, 1, 0, 32'h00000102, 4'b0011, 3'd2, 1, 2'd1, 0, 8'd0);
    step(8'd2, 1, 1, 0, 32'h00000102, 4'b0011, 3'd2, 1, 2'd0, 0, 8'd0);
    step(8'd1, 1, 1, 0, 32'h00000102, 4'b0011, 3'd2, 1, 2'd1, 0, 8'd0);
    step(8'd1, 1, 0, 0, 32'h00000201, 4'b0011, 3'd2, 1, 2'd1, 0, 8'd0);
    step(8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 3'd0, 0, 2'd0, 0, 8'd0);

    // Eviction, zero as a legal value, hit at slot 0
    step(8'd1, 1, 0, 0, 32'h00000001, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);
    step(8'd2, 1, 0, 0, 32'h00000102, 4'b0011, 3'd2, 0, 2'd0, 0, 8'd0);
    step(8'd3, 1, 0, 0, 32'h00010203, 4'b0111, 3'd3, 0, 2'd0, 0, 8'd0);
    step(8'd4, 1, 0, 0, 32'h01020304, 4'b1111, 3'd4, 0, 2'd0, 0, 8'd0);
    step(8'd5, 1, 0, 0, 32'h02030405, 4'b1111, 3'd4, 0, 2'd0, 1, 8'd1);
    step(8'd0, 1, 0, 0, 32'h03040500, 4'b1111, 3'd4, 0, 2'd0, 1, 8'd2);
    step(8'd0, 1, 0, 0, 32'h03040500, 4'b1111, 3'd4, 1, 2'd0, 0, 8'd0);
    step(8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 3'd0, 0, 2'd0, 0, 8'd0);

    // Qualifier toggling: only 7 and 8 are recorded
    step(8'd7, 1, 0, 0, 32'h00000007, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);
    step(8'd9, 0, 0, 0, 32'h00000007, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);
    step(8'd8, 1, 0, 0, 32'h00000708, 4'b0011, 3'd2, 0, 2'd0, 0, 8'd0);
    step(8'd9, 0, 0, 0, 32'h00000708, 4'b0011, 3'd2, 0, 2'd0, 0, 8'd0);

    // Reset right after an accepted sample: that sample is lost
    step(8'd3, 1, 0, 0, 32'h0, 4'b0, 3'd0, 0, 2'd0, 0, 8'd0, 1'b0);
    do_reset(1);
    step(8'd5, 1, 0, 0, 32'h00000005, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);
    step(8'd0, 0, 0, 0, 32'h00000005, 4'b0001, 3'd1, 0, 2'd0, 0, 8'd0);

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/distinct_history_tracker.md
Name: distinct_history_tracker

Overview:
- Tracks the last DEPTH distinct values seen on a qualified input stream.
- Presents them newest-first on a packed output bus with per-slot valid bits.
- Successor to the fixed 4-entry tracker. Adds parametrised depth, a valid qualifier, runtime move-to-front or keep-order mode, flush, hit reporting, eviction reporting and an occupancy count.
- Sits in the datapath as a registered sidecar. It never stalls upstream.

Parameters:
- DATA_W, default 8: data width in bits, ≥1.
- DEPTH, default 4: number of history slots, ≥2.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- reset_in  input  1  synchronous, active-high reset, held ≥1 cycle.
- data_in  input  DATA_W  sample value.
- valid_in  input  1  data_in is qualified this cycle.
- mode_in  input  1  0 = move-to-front, 1 = keep-order. Sampled with data_in.
- flush_in  input  1  clear history. Sampled with data_in.
- out_data  output  DEPTH*DATA_W  slot i at bits [i*DATA_W +: DATA_W]; slot 0 newest.
- out_valid  output  DEPTH  bit i = slot i holds a value.
- count_out  output  $clog2(DEPTH+1)  number of valid slots.
- hit_out  output  1  one-cycle pulse: the last update matched an existing slot.
- hit_idx_out  output  max(1,$clog2(DEPTH))  matched slot index, taken before reordering.
- evict_valid_out  output  1  one-cycle pulse: the oldest entry was pushed out.
- evict_data_out  output  DATA_W  value that was evicted.

Behaviour:
- Reset: while reset_in=1, every output, the input stage and all slots are 0.
- Reset mid-operation: reset discards any sample in flight.
- First accept: the sample presented on the first cycle after reset_in falls is accepted.
- Pipeline, 2 stages:
  - Edge 1 captures {data_in, valid_in, mode_in, flush_in} into the input stage.
  - Edge 2 updates the slots and the status outputs.
  - Outputs therefore reflect a sample on the 2nd rising edge after it is presented. Sustained throughput is one sample per cycle.
- Zero is a legal data value when valid_in=1. Validity comes only from out_valid, not from data content.
- Invariants:
  - out_valid is thermometer-coded (bit i set ⇒ bits 0..i-1 set).
  - Invalid slots hold 0.
  - count_out = popcount(out_valid).
- Match search compares staged data against valid slots only. With distinct contents at most one slot can match; priority is the lowest index.
- Staged valid=0, flush=0: slots hold. hit_out=0, evict_valid_out=0, evict_data_out=0.
- Miss (no match):
  - Shift slots 0..DEPTH-2 down by one; staged data goes into slot 0; out_valid shifts in a 1.
  - If count was DEPTH: evict_valid_out=1, evict_data_out = old slot DEPTH-1.
- Hit at slot k, mode 0 (move-to-front):
  - Slots 0..k-1 shift down one; staged data goes into slot 0; slots >k unchanged.
  - hit_out=1, hit_idx_out=k, count unchanged, no eviction.
  - k=0 leaves the slots unchanged.
- Hit at slot k, mode 1 (keep-order): slots unchanged; hit_out=1, hit_idx_out=k.
- hit_idx_out and evict_data_out read 0 whenever their pulse is 0.
- Flush staged:
  - All slots and out_valid are cleared at edge 2.
  - If the staged valid=1, the staged data is then written to slot 0 (out_valid=1, count=1).
  - No hit or evict pulse on a flush cycle; the evicted contents are not reported.
- Mode may change every cycle. Each sample is processed with its own staged mode.
- All outputs are driven directly from registers. No combinational path from inputs to outputs.

Test Plan:
- DEPTH=4, mode 0; reset, then valid stream 1 2 3 4 3 2 3 4 3 4 -> two edges after the last sample: slots 4,3,2,1, out_valid=4'b1111, count_out=4. Intermediate state after 1 2 3 4 3 is 3,4,2,1 with hit_out=1, hit_idx_out=1.
- DEPTH=4, mode 1; stream 1 2 1 2 1 -> slots 2,1,0,0, out_valid=4'b0011, count_out=2. hit_out pulses on each of the last three samples, with hit_idx_out=1,0,1.
- DEPTH=4, mode 0; stream 1 2 3 4 5 -> slots 5,4,3,2. evict_valid_out pulses once with evict_data_out=1. Then 0 -> slots 0,5,4,3, evict_data_out=2. The 0 is a valid entry.
- valid_in toggled 1,0,1,0 with data 7,9,8,9 -> only 7 and 8 are recorded: slots 8,7. No status pulses on the idle cycles.
- With slots 4,3,2,1: flush_in=1 with valid_in=0 -> all outputs 0 after 2 edges. flush_in=1 with valid_in=1, data=6 -> slots 6,0,0,0, count_out=1, no evict pulse.
- reset_in asserted one cycle mid-stream, immediately after a sample was accepted -> all outputs 0 during reset. The in-flight sample is lost. The sample presented on the first cycle after reset lands in slot 0 two edges later.
